xgmii_baser_rx_link_fault: RTL and testbench
============================================

# xgmii_baser_rx_link_fault

Link-fault monitor sitting directly downstream of the 10GBASE-R RX decoder on the 64-bit XGMII receive path. Scans each decoded word for local-fault (LF) and remote-fault (RF) sequence ordered sets in lane 0 and lane 4, and runs the 802.3 clause-46 counting state machine. Produces registered link-fault status and the TX-side requests: send RF on local fault, send idle on remote fault.

## Interface
- DATA_WIDTH, 64, XGMII data width; only 64 supported.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
- WINDOW_COLS, 128, fault-free columns that clear the fault state; power of two, 4..1024.
- clk  input  1  core clock, one XGMII word per cycle.
- rst  input  1  reset, synchronous, active-high.
- xgmii_rxd  input  64  decoded XGMII data.
- xgmii_rxc  input  8  decoded XGMII control, one bit per byte.
- rx_bad_block  input  1  decoder bad-block flag, aligned with xgmii_rxd/xgmii_rxc.
- rx_local_fault  output  1  link_fault == LOCAL.
- rx_remote_fault  output  1  link_fault == REMOTE.
- tx_req_remote_fault  output  1  TX must send RF sequences; equals rx_local_fault.
- tx_req_idle  output  1  TX must send idle only; equals rx_remote_fault.
- stat_lf_count, stat_rf_count, stat_bad_block_count  output  16 each  present only with LINK_FAULT_STATS_EN.

## Operation
- Each word holds two columns: column A = bytes 0-3, column B = bytes 4-7. Column A is processed before column B.
- Fault column: rxc nibble == 4'b0001, byte0 == 8'h9c, byte1 == byte2 == 8'h00, byte3 == 8'h01 (LF) or 8'h02 (RF).
- Any other column, including other 9c sequences, is non-fault.
- Word with rx_bad_block == 1: both columns are non-fault regardless of content.
- State: link_fault ∈ {OK, LOCAL, REMOTE}; seq_type (LF/RF); seq_cnt 0..4 (saturating); col_cnt 0..WINDOW_COLS (saturating).
- Fault column of type T:
  - If seq_cnt == 0 or seq_type != T: seq_type = T, seq_cnt = 1.
  - Otherwise seq_cnt = min(seq_cnt + 1, 4).
  - col_cnt = 0.
  - When seq_cnt reaches 4: link_fault = T.
- Non-fault column:
  - col_cnt = min(col_cnt + 1, WINDOW_COLS).
  - When col_cnt reaches WINDOW_COLS: seq_cnt = 0, link_fault = OK.
- Both column updates in one cycle are chained combinationally; column B sees column A's result.
- A type change while link_fault ≠ OK keeps link_fault unchanged until the new type reaches 4 or the window expires.

## Timing
- All outputs registered; latency 1 cycle from the input word to the status change.
- Reset: link_fault = OK, seq_cnt = 0, col_cnt = 0, seq_type = LF; all outputs 0, including stat counters.
- rst has priority over any same-cycle input.
- Reset mid-fault deasserts rx_local_fault/rx_remote_fault the cycle after rst is sampled. The first input word is evaluated the cycle rst is low.
- No input handshake; every cycle carries a valid word.

## Configuration
- LINK_FAULT_STATS_EN defined: three 16-bit saturating counters, cleared only by rst.
  - stat_lf_count and stat_rf_count add 0, 1 or 2 per cycle (fault columns of that type in the word).
  - stat_bad_block_count adds 1 per cycle with rx_bad_block high.
  - Counters hold at 16'hffff.
  - Registered; they update in the same cycle as the status outputs.
- LINK_FAULT_STATS_EN undefined: the counters and their ports are absent; the rest of the behaviour is unchanged.

## Test plan
- LF column in lane 0, idle in lane 4, 4 consecutive cycles -> rx_local_fault = tx_req_remote_fault = 1 one cycle after the 4th word; rx_remote_fault = 0.
- RF in both lanes for 2 cycles -> rx_remote_fault = tx_req_idle = 1 one cycle after the 2nd word.
- Alternating LF/RF columns for 100 cycles -> rx_local_fault and rx_remote_fault stay 0.
- Local fault established, then 64 idle words (128 columns) -> rx_local_fault drops one cycle after the 64th idle word, not after the 63rd.
- 3 LF columns, then 64 idle words, then 1 LF column -> no fault; seq_cnt restarts at 1.
- 3 LF columns, then 1 LF column in a word with rx_bad_block = 1 -> no fault.
- Local fault asserted, then rst for 1 cycle -> all outputs 0 next cycle; the state rebuilds only after 4 fresh LF columns.
- With LINK_FAULT_STATS_EN: 70000 cycles of dual-lane LF -> stat_lf_count saturates at 16'hffff.

Source files
------------

// File: rtl/xgmii_baser_rx_link_fault.sv
// Link-fault monitor on the 64-bit XGMII RX path: LF/RF ordered-set counting,
// registered fault status, TX requests; stats counters when LINK_FAULT_STATS_EN.
//
// Ports:
//   clk, rst (sync, active-high)
//   xgmii_rxd[63:0], xgmii_rxc[7:0], rx_bad_block   decoded RX word
//   rx_local_fault, rx_remote_fault                 link status
//   tx_req_remote_fault, tx_req_idle                TX-side requests
//   stat_lf_count, stat_rf_count, stat_bad_block_count (LINK_FAULT_STATS_EN only)
module xgmii_baser_rx_link_fault #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int WINDOW_COLS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  input  logic                  rx_bad_block,
  output logic                  rx_local_fault,
  output logic                  rx_remote_fault,
  output logic                  tx_req_remote_fault,
`ifdef LINK_FAULT_STATS_EN
  output logic                  tx_req_idle,
  output logic [15:0]           stat_lf_count,
  output logic [15:0]           stat_rf_count,
  output logic [15:0]           stat_bad_block_count
`else
  output logic                  tx_req_idle
`endif
);

  localparam int CW = $clog2(WINDOW_COLS + 1);
  localparam logic [CW-1:0] WIN = CW'(WINDOW_COLS);

  typedef enum logic [1:0] {
    LF_OK,
    LF_LOCAL,
    LF_REMOTE
  } fault_e;

  // typ: 0 = LF sequence, 1 = RF sequence
  typedef struct packed {
    fault_e        lf;
    logic          typ;
    logic [2:0]    seq;
    logic [CW-1:0] col;
  } st_t;

  // {is_fault, is_rf} for one 4-byte column
  function automatic logic [1:0] col_decode(
    input logic [31:0] d,
    input logic [3:0]  c
  );
    logic hdr;
    logic lf;
    logic rf;
    hdr = (c == 4'b0001) && (d[23:0] == 24'h00009c);
    lf  = (d[31:24] == 8'h01);
    rf  = (d[31:24] == 8'h02);
    return {hdr && (lf || rf), rf};
  endfunction

  function automatic st_t step(
    input st_t  s,
    input logic is_f,
    input logic t
  );
    st_t n;
    n = s;
    if (is_f) begin
      if (s.seq == 3'd0 || s.typ != t) begin
        n.typ = t;
        n.seq = 3'd1;
      end else if (s.seq < 3'd4) begin
        n.seq = s.seq + 3'd1;
      end
      n.col = '0;
      if (n.seq == 3'd4) n.lf = t ? LF_REMOTE : LF_LOCAL;
    end else begin
      if (s.col < WIN) n.col = s.col + CW'(1);
      if (n.col == WIN) begin
        n.seq = 3'd0;
        n.lf  = LF_OK;
      end
    end
    return n;
  endfunction

  st_t        st;
  st_t        st_a;
  st_t        st_b;
  logic [1:0] dec_a;
  logic [1:0] dec_b;
  logic       fa;
  logic       fb;

  always_comb begin
    dec_a = col_decode(xgmii_rxd[31:0], xgmii_rxc[3:0]);
    dec_b = col_decode(xgmii_rxd[63:32], xgmii_rxc[7:4]);
    fa    = dec_a[1] & ~rx_bad_block;
    fb    = dec_b[1] & ~rx_bad_block;
    // column B sees column A's result in the same cycle
    st_a  = step(st, fa, dec_a[0]);
    st_b  = step(st_a, fb, dec_b[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st                  <= '{lf: LF_OK, typ: 1'b0, seq: 3'd0, col: '0};
      rx_local_fault      <= 1'b0;
      rx_remote_fault     <= 1'b0;
      tx_req_remote_fault <= 1'b0;
      tx_req_idle         <= 1'b0;
    end else begin
      st                  <= st_b;
      rx_local_fault      <= (st_b.lf == LF_LOCAL);
      rx_remote_fault     <= (st_b.lf == LF_REMOTE);
      tx_req_remote_fault <= (st_b.lf == LF_LOCAL);
      tx_req_idle         <= (st_b.lf == LF_REMOTE);
    end
  end

`ifdef LINK_FAULT_STATS_EN
  function automatic logic [15:0] sat_add(
    input logic [15:0] c,
    input logic [1:0]  i
  );
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, i};
    return s[16] ? 16'hffff : s[15:0];
  endfunction

  logic [1:0] lf_inc;
  logic [1:0] rf_inc;

  always_comb begin
    lf_inc = {1'b0, fa & ~dec_a[0]} + {1'b0, fb & ~dec_b[0]};
    rf_inc = {1'b0, fa & dec_a[0]} + {1'b0, fb & dec_b[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lf_count        <= 16'h0;
      stat_rf_count        <= 16'h0;
      stat_bad_block_count <= 16'h0;
    end else begin
      stat_lf_count        <= sat_add(stat_lf_count, lf_inc);
      stat_rf_count        <= sat_add(stat_rf_count, rf_inc);
      stat_bad_block_count <= sat_add(stat_bad_block_count,
                                      {1'b0, rx_bad_block});
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_baser_rx_link_fault.sv
// Directed bench for xgmii_baser_rx_link_fault.
// Stats checks compile in with LINK_FAULT_STATS_EN.
module tb_xgmii_baser_rx_link_fault;

  localparam logic [31:0] LFC = 32'h0100009c;
  localparam logic [31:0] RFC = 32'h0200009c;
  localparam logic [31:0] IDC = 32'h07070707;
  localparam logic [3:0]  FK  = 4'h1;
  localparam logic [3:0]  IK  = 4'hf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] xgmii_rxd = {IDC, IDC};
  logic [7:0]  xgmii_rxc = 8'hff;
  logic        rx_bad_block = 1'b0;
  logic        rx_local_fault;
  logic        rx_remote_fault;
  logic        tx_req_remote_fault;
  logic        tx_req_idle;
`ifdef LINK_FAULT_STATS_EN
  logic [15:0] stat_lf_count;
  logic [15:0] stat_rf_count;
  logic [15:0] stat_bad_block_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic saw;

  xgmii_baser_rx_link_fault dut (
    .clk                 (clk),
    .rst                 (rst),
    .xgmii_rxd           (xgmii_rxd),
    .xgmii_rxc           (xgmii_rxc),
    .rx_bad_block        (rx_bad_block),
    .rx_local_fault      (rx_local_fault),
    .rx_remote_fault     (rx_remote_fault),
    .tx_req_remote_fault (tx_req_remote_fault),
`ifdef LINK_FAULT_STATS_EN
    .tx_req_idle         (tx_req_idle),
    .stat_lf_count       (stat_lf_count),
    .stat_rf_count       (stat_rf_count),
    .stat_bad_block_count(stat_bad_block_count)
`else
    .tx_req_idle         (tx_req_idle)
`endif
  );

  always #5 clk = ~clk;

  task automatic word(
    input logic [31:0] a,
    input logic [3:0]  ac,
    input logic [31:0] b,
    input logic [3:0]  bc,
    input logic        bb
  );
    xgmii_rxd    = {b, a};
    xgmii_rxc    = {bc, ac};
    rx_bad_block = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic w_lf_idle();
    word(LFC, FK, IDC, IK, 1'b0);
  endtask

  task automatic w_lf_lf();
    word(LFC, FK, LFC, FK, 1'b0);
  endtask

  task automatic w_idle(input int n);
    for (int i = 0; i < n; i++) word(IDC, IK, IDC, IK, 1'b0);
  endtask

  task automatic chk(input string tag, input logic lf, input logic rf);
    logic [3:0] got;
    logic [3:0] exp;
    got = {rx_local_fault, rx_remote_fault, tx_req_remote_fault, tx_req_idle};
    exp = {lf, rf, lf, rf};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got lf/rf/txrf/txidle=%b expected %b", tag, got, exp);
    end
  endtask

`ifdef LINK_FAULT_STATS_EN
  task automatic chk_stats(
    input string       tag,
    input logic [15:0] lf,
    input logic [15:0] rf,
    input logic [15:0] bb
  );
    vectors++;
    assert ({stat_lf_count, stat_rf_count, stat_bad_block_count}
            === {lf, rf, bb}) else begin
      miscompares++;
      $error("FAIL %s: got lf=%h rf=%h bb=%h expected lf=%h rf=%h bb=%h",
             tag, stat_lf_count, stat_rf_count, stat_bad_block_count,
             lf, rf, bb);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 1'b0, 1'b0);
`ifdef LINK_FAULT_STATS_EN
    chk_stats("reset_stats", 16'h0, 16'h0, 16'h0);
`endif
    rst = 1'b0;

    // four LF columns in lane 0
    w_lf_idle();
    w_lf_idle();
    w_lf_idle();
    chk("lf_3cols", 1'b0, 1'b0);
    w_lf_idle();
    chk("lf_4cols", 1'b1, 1'b0);

    // window expiry: col_cnt = 1 here, 128 reached in idle word 64
    w_idle(63);
    chk("win_63", 1'b1, 1'b0);
    w_idle(1);
    chk("win_64", 1'b0, 1'b0);

    // RF in both lanes
    word(RFC, FK, RFC, FK, 1'b0);
    chk("rf_1word", 1'b0, 1'b0);
    word(RFC, FK, RFC, FK, 1'b0);
    chk("rf_2words", 1'b0, 1'b1);
    w_idle(64);
    chk("rf_clear", 1'b0, 1'b0);

    // alternating LF/RF columns never reach 4
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      word(LFC, FK, RFC, FK, 1'b0);
      saw = saw | rx_local_fault | rx_remote_fault;
    end
    vectors++;
    assert (saw === 1'b0) else begin
      miscompares++;
      $error("FAIL alt_any: got fault seen=%b expected 0", saw);
    end
    chk("alt_end", 1'b0, 1'b0);

    // 3 LF, window, 1 LF: count restarts at 1
    w_lf_lf();
    w_lf_idle();
    w_idle(64);
    w_lf_idle();
    chk("restart_1", 1'b0, 1'b0);
    w_lf_lf();
    chk("restart_3", 1'b0, 1'b0);
    w_lf_idle();
    chk("restart_4", 1'b1, 1'b0);
    w_idle(64);
    chk("restart_clr", 1'b0, 1'b0);

    // LF column inside a bad block is ignored
    w_lf_lf();
    w_lf_idle();
    word(LFC, FK, IDC, IK, 1'b1);
    chk("bad_block", 1'b0, 1'b0);
    w_idle(64);
    chk("bad_clr", 1'b0, 1'b0);

    // reset mid-fault, rst wins over a same-cycle LF word
    w_lf_lf();
    w_lf_lf();
    chk("pre_rst", 1'b1, 1'b0);
    rst = 1'b1;
    w_lf_lf();
    chk("rst_mid", 1'b0, 1'b0);
`ifdef LINK_FAULT_STATS_EN
    chk_stats("rst_mid_stats", 16'h0, 16'h0, 16'h0);
`endif
    rst = 1'b0;
    w_lf_idle();
    w_lf_idle();
    w_lf_idle();
    chk("rebuild_3", 1'b0, 1'b0);
    w_lf_idle();
    chk("rebuild_4", 1'b1, 1'b0);

`ifdef LINK_FAULT_STATS_EN
    chk_stats("stats_4lf", 16'd4, 16'h0, 16'h0);
    word(LFC, FK, RFC, FK, 1'b1);
    chk_stats("stats_bad", 16'd4, 16'h0, 16'd1);
    word(RFC, FK, RFC, FK, 1'b0);
    chk_stats("stats_rf", 16'd4, 16'd2, 16'd1);
    for (int i = 0; i < 70000; i++) w_lf_lf();
    chk_stats("stats_sat", 16'hffff, 16'd2, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
